fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the RV32 core. Owns the program counter, issues word reads to the synchronous instruction memory (one-cycle read latency, byte address, word access), and buffers returned instructions with their PC in a 2-entry queue presented to decode over a valid/ready handshake. Handles control-flow redirects from execute and flags fetches that are misaligned or outside the instruction memory window.

## Interface

- `RESET_PC`, 32'h0100_0000: first fetch address after reset.
- `IMEM_BASE`, 32'h0100_0000: byte base address of the instruction memory window.
- `IMEM_WORDS`, 1024: window size in 32-bit words (4 KB).
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `imem_rd` out 1: read strobe to instruction memory.
- `imem_addr` out 32: byte address of the read; bits [1:0] always 0 when `imem_rd`=1.
- `imem_instr` in 32: memory data; valid the cycle after an `imem_rd`=1 edge; holds when `imem_rd`=0.
- `redirect_valid` in 1: one-cycle pulse, new PC from execute (branch/jump/trap).
- `redirect_pc` in 32: target byte address.
- `id_valid` out 1: queue head valid.
- `id_ready` in 1: decode accepts head this cycle.
- `id_instr` out 32: head instruction.
- `id_pc` out 32: head PC.
- `id_fault` out 1: head is a fetch fault; `id_instr` = 32'h0000_0013 (NOP).

## Operation

- Reset: `pc`=RESET_PC, queue empty, `inflight`=0, state RUN. Outputs during reset: `imem_rd`=0, `imem_addr`=RESET_PC, `id_valid`=0, `id_instr`=0, `id_pc`=0, `id_fault`=0.
- States: RUN (fetching), HALT (fault entry enqueued, no further reads). HALT→RUN only on `redirect_valid`.
- Fetch address: `fa` = `redirect_pc` when `redirect_valid`, else `pc`. `imem_addr` = `fa` (combinational path from `redirect_pc` is intended).
- `fa` is legal iff `fa`[1:0]==0 and (`fa` − IMEM_BASE) < 4·IMEM_WORDS (32-bit unsigned subtract; below-base addresses wrap large and are illegal).
- Credit: `slots` = `count` + `inflight` − (`id_valid` & `id_ready`). Issue allowed iff `slots` < 2 (2 when `redirect_valid`, since the flush frees everything).
- Issue in RUN (or on redirect) with credit and legal `fa`: `imem_rd`=1; next `pc` = `fa`+4; `inflight`←1; the PC of the request is recorded for the response.
- Illegal `fa` with credit: `imem_rd`=0; enqueue fault entry {NOP, `fa`, fault=1} directly next edge; state→HALT.
- Response: when `inflight`=1, next cycle `imem_instr` is enqueued with recorded PC, fault=0.
- Redirect: queue cleared; the response arriving in the redirect cycle is discarded (not enqueued); the same-cycle issue uses `redirect_pc`. Redirect overrides a simultaneous decode pop (popped entry counts as consumed) and HALT.
- Sequential run off the window end (`pc` = IMEM_BASE+4·IMEM_WORDS) yields a fault entry, not a wrap to IMEM_BASE.
- Queue full with `id_ready`=0: no issue, `imem_rd`=0, `pc` unchanged; no entry ever lost.

## Timing

- Request at edge k → data on `imem_instr` after k → enqueued at k+1 → `id_valid`=1 after k+1. First `id_valid` 2 cycles after `rst_n` release.
- Steady state with `id_ready`=1: one instruction per cycle, sequential PCs.
- Redirect at cycle r: target instruction at decode after edge r+1 (1-cycle bubble).
- `id_*` outputs come straight from queue registers; they hold while `id_valid`=1 and `id_ready`=0.
- `rst_n` assertion mid-operation clears state immediately (asynchronously); in-flight data is dropped.

## Structure

- Shared package `fetch_pkg`: `NOP_INSTR`=32'h0000_0013, default RESET_PC/IMEM_BASE, state enum {RUN, HALT}, queue entry struct {instr[31:0], pc[31:0], fault}.
- Sub-module `fetch_buffer`: 2-entry FIFO of entries with push/pop/flush, `count` output, async active-low reset.
- Top holds PC, `inflight`, recorded request PC, FSM, legality check.

## Test plan

- Reset release, `id_ready`=1 → `imem_addr` 0x0100_0000, 0x0100_0004, …; `id_pc` sequence matches, first `id_valid` 2 cycles after release.
- `id_ready`=0 for 5 cycles → queue fills at 2 entries, `imem_rd`=0, `id_instr`/`id_pc` stable; on release, no gap or duplicate.
- `redirect_valid` with `redirect_pc`=0x0100_0100 while queue holds 2 entries → both flushed, next `id_pc`=0x0100_0100 one bubble later, stale response not delivered.
- `redirect_pc`=0x0100_0102 → entry with `id_fault`=1, `id_instr`=0x0000_0013, `id_pc`=0x0100_0102, `imem_rd` stays 0 until next redirect.
- Redirect to 0x0100_0FFC → instruction at 0x0100_0FFC, then fault entry with `id_pc`=0x0100_1000; redirect to 0x00FF_FFFC → immediate fault.
- Assert `rst_n` while `inflight`=1 and queue non-empty → `id_valid`=0 immediately, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
//   Shared definitions for the RV32 instruction fetch stage:
//     NOP_INSTR         - instruction substituted for faulted fetches
//     DEF_RESET_PC      - default first fetch address after reset
//     DEF_IMEM_BASE     - default byte base of the instruction memory window
//     DEF_IMEM_WORDS    - default window size in 32-bit words
//     fetch_state_e     - fetch FSM states (RUN / HALT)
//     fetch_entry_t     - one decode-queue entry {instr, pc, fault}
//     fetch_addr_legal  - alignment + window check for a fetch address
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR      = 32'h0000_0013;
    localparam logic [31:0] DEF_RESET_PC   = 32'h0100_0000;
    localparam logic [31:0] DEF_IMEM_BASE  = 32'h0100_0000;
    localparam int unsigned DEF_IMEM_WORDS = 1024;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        fault;
    } fetch_entry_t;

    // Word aligned and inside [base, base + 4*words). The unsigned subtract
    // makes addresses below the base wrap to huge offsets, so one compare
    // covers both ends of the window.
    function automatic logic fetch_addr_legal(input logic [31:0] addr,
                                              input logic [31:0] base,
                                              input int unsigned words);
        logic [31:0] offset;
        offset = addr - base;
        return (addr[1:0] == 2'b00) && (offset < (words << 2));
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// -----------------------------------------------------------------------------
// fetch_buffer
//   Two-entry in-order queue between instruction fetch and decode. The head
//   entry lives in a fixed register so decode sees registered outputs.
//   Two push ports are provided because a memory response and a fault entry
//   can be appended on the same edge; port a is always the older entry.
//
//   Ports
//     clk, rst_n        - clock, asynchronous active-low reset
//     flush             - discard every stored entry (pushes still land)
//     pop               - head consumed this cycle (ignored when empty)
//     push_a, entry_a   - append older entry
//     push_b, entry_b   - append younger entry (after entry_a if both)
//     head              - current head entry
//     count             - number of valid entries (0..2)
// -----------------------------------------------------------------------------
module fetch_buffer
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         pop,
    input  logic         push_a,
    input  fetch_entry_t entry_a,
    input  logic         push_b,
    input  fetch_entry_t entry_b,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t slot_q [2];
    fetch_entry_t slot_d [2];
    logic [1:0]   count_q;
    logic [1:0]   count_d;

    // Survivors (after flush or pop) are compacted toward slot 0, then the
    // pushes are appended in age order. The producer guarantees the total
    // never exceeds two; the bound checks only keep the indexing safe.
    always_comb begin
        // NOTE: every variable gets a default at the top of the block so no
        // path leaves it unassigned, which is what would infer a latch.
        slot_d  = slot_q;
        count_d = count_q;

        if (flush) begin
            count_d = 2'd0;
        end else if (pop && (count_q != 2'd0)) begin
            slot_d[0] = slot_q[1];
            count_d   = count_q - 2'd1;
        end

        if (push_a && (count_d < 2'd2)) begin
            slot_d[count_d[0]] = entry_a;
            count_d            = count_d + 2'd1;
        end

        if (push_b && (count_d < 2'd2)) begin
            slot_d[count_d[0]] = entry_b;
            count_d            = count_d + 2'd1;
        end
    end

    // NOTE: the storage is reset too, not just the count, because the head
    // slot drives decode directly and must read as zero during reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q[0] <= '0;
            slot_q[1] <= '0;
            count_q   <= 2'd0;
        end else begin
            // NOTE: non-blocking assignments for all state so every register
            // samples the pre-edge values regardless of statement order.
            slot_q[0] <= slot_d[0];
            slot_q[1] <= slot_d[1];
            count_q   <= count_d;
        end
    end

    assign head  = slot_q[0];
    assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage of the RV32 core. Owns the PC, issues word reads
//   to a one-cycle-latency synchronous instruction memory and queues the
//   returned instructions (with their PC) for decode in a 2-entry buffer.
//   Redirects from execute flush the queue and restart fetch at the target;
//   misaligned or out-of-window fetches produce a single fault entry (NOP)
//   and halt fetching until the next redirect.
//
//   Parameters
//     RESET_PC    - first fetch address after reset
//     IMEM_BASE   - byte base of the instruction memory window
//     IMEM_WORDS  - window size in 32-bit words
//
//   Ports
//     clk, rst_n                  - clock, asynchronous active-low reset
//     imem_rd, imem_addr          - read strobe and byte address to memory
//     imem_instr                  - read data, valid the cycle after imem_rd
//     redirect_valid, redirect_pc - one-cycle control-flow redirect
//     id_valid, id_ready          - decode handshake on the queue head
//     id_instr, id_pc, id_fault   - queue head contents
// -----------------------------------------------------------------------------
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
    parameter logic [31:0] IMEM_BASE  = DEF_IMEM_BASE,
    parameter int unsigned IMEM_WORDS = DEF_IMEM_WORDS
)(
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_rd,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic        id_fault
);

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  req_pc_q, req_pc_d;   // PC of the read now in flight
    logic         inflight_q, inflight_d;

    // ---------------------------------------------------------------------
    // Queue interface
    // ---------------------------------------------------------------------
    fetch_entry_t head;
    logic [1:0]   count;
    logic         pop;
    logic         push_rsp;
    logic         push_fault;
    fetch_entry_t rsp_entry;
    fetch_entry_t fault_entry;

    // ---------------------------------------------------------------------
    // Fetch decision
    // ---------------------------------------------------------------------
    logic [31:0]  fa;
    logic         fa_legal;
    logic [2:0]   slots;
    logic         credit;
    logic         act;
    logic         issue;
    logic         fault;

    assign id_valid = (count != 2'd0);
    assign pop      = id_valid && id_ready;

    always_comb begin
        fa       = redirect_valid ? redirect_pc : pc_q;
        fa_legal = fetch_addr_legal(fa, IMEM_BASE, IMEM_WORDS);

        // Entries that will occupy the queue once everything already owed
        // (stored + in flight) has landed, net of this cycle's pop. A
        // redirect discards all of that, so it always has room.
        slots  = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};
        credit = redirect_valid || (slots < 3'd2);

        // Reset gates the strobe so memory sees no read while rst_n is low.
        act   = rst_n && credit && (redirect_valid || (state_q == RUN));
        issue = act && fa_legal;
        fault = act && !fa_legal;
    end

    // Next-state logic: PC, in-flight tracking and the RUN/HALT FSM.
    always_comb begin
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = 1'b0;
        state_d    = state_q;

        if (issue) begin
            pc_d       = fa + 32'd4;
            req_pc_d   = fa;
            inflight_d = 1'b1;
            state_d    = RUN;
        end else if (fault) begin
            state_d    = HALT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            req_pc_q   <= RESET_PC;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
        end
    end

    // ---------------------------------------------------------------------
    // Queue writes. A response landing in a redirect cycle belongs to the
    // abandoned path and is dropped; a fault entry is younger than any
    // response arriving in the same cycle, hence port b.
    // ---------------------------------------------------------------------
    assign push_rsp    = inflight_q && !redirect_valid;
    assign rsp_entry   = '{instr: imem_instr, pc: req_pc_q, fault: 1'b0};
    assign push_fault  = fault;
    assign fault_entry = '{instr: NOP_INSTR, pc: fa, fault: 1'b1};

    fetch_buffer u_buffer (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (redirect_valid),
        .pop     (pop),
        .push_a  (push_rsp),
        .entry_a (rsp_entry),
        .push_b  (push_fault),
        .entry_b (fault_entry),
        .head    (head),
        .count   (count)
    );

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign imem_rd   = issue;
    assign imem_addr = rst_n ? fa : RESET_PC;
    assign id_instr  = head.instr;
    assign id_pc     = head.pc;
    assign id_fault  = head.fault;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Self-checking bench for fetch_unit. A transaction-level reference model
//   (PC, halt flag, one pending read, and a queue of expected decode entries)
//   predicts the fetch strobe/address and the decode head every cycle.
//   Instruction memory is modelled as a pure function of the address.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0100_0000;
    localparam logic [31:0] BASE   = 32'h0100_0000;
    localparam int unsigned WORDS  = 1024;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_rd;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_fault;

    fetch_unit #(
        .RESET_PC   (RST_PC),
        .IMEM_BASE  (BASE),
        .IMEM_WORDS (WORDS)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_rd        (imem_rd),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_fault       (id_fault)
    );

    always #5 clk = ~clk;

    // Distinct, address-derived contents for every word.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0] ^ 16'h5A3C};
    endfunction

    // Synchronous instruction memory: one-cycle latency, holds otherwise.
    always @(posedge clk) begin
        if (imem_rd) imem_instr <= mem_word(imem_addr);
    end

    // ---------------------------------------------------------------------
    // Reference model
    // ---------------------------------------------------------------------
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        fault;
    } exp_entry_t;

    exp_entry_t  q[$];
    logic [31:0] m_pc;
    bit          m_halt;
    bit          m_pend;
    logic [31:0] m_pend_pc;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit in_window(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a >= BASE) && (a <= BASE + 4 * WORDS - 4);
    endfunction

    task automatic model_reset();
        q.delete();
        m_pc      = RST_PC;
        m_halt    = 1'b0;
        m_pend    = 1'b0;
        m_pend_pc = '0;
    endtask

    // Called just after a falling edge: drive inputs, check outputs, advance
    // the model, then move to the next falling edge.
    task automatic step(input bit redir, input logic [31:0] rpc, input bit rdy);
        logic [31:0] fa;
        bit          legal, pop, may, credit, exp_rd;
        int          occ;

        redirect_valid = redir;
        redirect_pc    = rpc;
        id_ready       = rdy;
        #1;

        fa     = redir ? rpc : m_pc;
        legal  = in_window(fa);
        pop    = (q.size() != 0) && rdy;
        occ    = q.size() + int'(m_pend) - int'(pop);
        may    = redir || !m_halt;
        credit = redir || (occ < 2);
        exp_rd = may && credit && legal;

        check("imem_rd",   32'(imem_rd),  32'(exp_rd));
        check("imem_addr", imem_addr,     fa);
        check("id_valid",  32'(id_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            check("id_instr", id_instr,       q[0].instr);
            check("id_pc",    id_pc,          q[0].pc);
            check("id_fault", 32'(id_fault),  32'(q[0].fault));
        end

        if (pop) void'(q.pop_front());
        if (redir) q.delete();
        else if (m_pend) q.push_back('{mem_word(m_pend_pc), m_pend_pc, 1'b0});

        if (may && credit) begin
            if (legal) begin
                m_pend    = 1'b1;
                m_pend_pc = fa;
                m_pc      = fa + 32'd4;
                m_halt    = 1'b0;
            end else begin
                q.push_back('{NOP, fa, 1'b1});
                m_pend = 1'b0;
                m_halt = 1'b1;
            end
        end else begin
            m_pend = 1'b0;
        end

        @(posedge clk);
        @(negedge clk);
    endtask

    // Called just after a falling edge; asserts reset asynchronously, checks
    // the reset-state outputs, and releases reset on a later falling edge.
    task automatic do_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        id_ready       = 1'b0;
        #1;
        check("rst_imem_rd",   32'(imem_rd),  32'd0);
        check("rst_imem_addr", imem_addr,     RST_PC);
        check("rst_id_valid",  32'(id_valid), 32'd0);
        check("rst_id_instr",  id_instr,      32'd0);
        check("rst_id_pc",     id_pc,         32'd0);
        check("rst_id_fault",  32'(id_fault), 32'd0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] pick_target();
        logic [31:0] t;
        case ($urandom_range(0, 4))
            0:       t = BASE + 4 * $urandom_range(0, WORDS - 1);
            1:       t = BASE + 4 * $urandom_range(WORDS - 8, WORDS - 1);
            2:       t = (BASE + $urandom_range(0, 4 * WORDS - 1)) | 32'd1;
            3:       t = BASE - 4 * $urandom_range(1, 8);
            default: t = BASE + 4 * WORDS + 4 * $urandom_range(0, 3);
        endcase
        return t;
    endfunction

    initial begin
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        id_ready       = 1'b0;
        @(negedge clk);
        do_reset();

        // Sequential fetch from RESET_PC with decode always ready.
        for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b1);

        // Decode stalls for 5 cycles, then resumes.
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1);

        // Fill the queue, redirect over it, drain.
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0);
        step(1'b1, 32'h0100_0100, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1);

        // Misaligned redirect: fault entry then no reads until next redirect.
        step(1'b1, 32'h0100_0102, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'($urandom_range(0, 1)));

        // Last word of the window, then run off its end.
        step(1'b1, 32'h0100_0FFC, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1);

        // Below the window base.
        step(1'b1, 32'h00FF_FFFC, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);

        // Reset while a read is in flight and the queue holds an entry.
        step(1'b1, 32'h0100_0010, 1'b0);
        step(1'b0, '0, 1'b0);
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            bit          rd;
            logic [31:0] tgt;
            rd  = ($urandom_range(0, 99) < 8);
            tgt = rd ? pick_target() : 32'($urandom);
            step(rd, tgt, ($urandom_range(0, 99) < 70));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
